// File: rtl/cordic_pkg.sv
// cordic_pkg -- shared types and defaults for the CORDIC request arbiter.
//   req_id_t    : requester identifier (0 or 1), stored in the tag queue
//   arb_state_t : arbiter state machine encoding IDLE/RUN/FLUSH
//   req_t       : one requester's offer (valid + operand word)
//   DEF_MAX_OUT, DEF_TIMEOUT_CYC : default parameter values
package cordic_pkg;

    localparam int DATA_W          = 32;
    localparam int DEF_MAX_OUT     = 4;
    localparam int DEF_TIMEOUT_CYC = 256;

    typedef logic req_id_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic              vld;
        logic [DATA_W-1:0] data;
    } req_t;

endpackage

// File: rtl/cordic_tag_fifo.sv
// cordic_tag_fifo -- in-order queue of requester IDs for jobs in flight.
// Ports:
//   HCLK, HRESET : clock, asynchronous active-high reset
//   flush        : empties the queue (takes priority over push/pop)
//   push/push_id : enqueue one ID
//   pop          : dequeue the head ID (ignored when empty)
//   head_id      : ID at the head of the queue
//   empty        : queue holds no entries
// DEPTH must be a power of two so the pointers wrap naturally.
module cordic_tag_fifo
    import cordic_pkg::*;
#(
    parameter int DEPTH = DEF_MAX_OUT
) (
    input  logic    HCLK,
    input  logic    HRESET,
    input  logic    flush,
    input  logic    push,
    input  req_id_t push_id,
    input  logic    pop,
    output req_id_t head_id,
    output logic    empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full, do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign do_pop  = pop && !empty;
    // A full queue can still take a push when a pop frees the head slot.
    assign do_push = push && (!full || do_pop);
    assign head_id = mem[rd_ptr];

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_id;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/cordic_arbiter.sv
// cordic_arbiter -- shares one pipelined CORDIC core between two requesters.
// Round-robin issue, up to MAX_OUT jobs in flight, results routed back in
// issue order through a tag queue of requester IDs.
// Optional watchdog: define CORDIC_ARB_TIMEOUT_EN to enable it; a stuck job
// then forces a one-cycle FLUSH that drops all outstanding work.
// Ports:
//   HCLK, HRESET           : clock, asynchronous active-high reset
//   reqN_valid/data/ready  : operand offer / accept from requester N
//   cor_in, cor_valid_in   : issue to the core (cor_in is 0 when idle)
//   cor_out, cor_valid_out : result from the core
//   rspN_valid, rsp_data   : registered one-cycle result pulse to requester N
//   busy                   : any job outstanding
//   timeout_err            : one-cycle watchdog pulse (0 without the macro)
module cordic_arbiter
    import cordic_pkg::*;
#(
    parameter int MAX_OUT     = DEF_MAX_OUT,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic [DATA_W-1:0] cor_in,
    output logic              cor_valid_in,
    input  logic              cor_valid_out,
    input  logic [DATA_W-1:0] cor_out,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              timeout_err
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);
    // A misconfigured instance refuses all work instead of corrupting the
    // tag queue.
    localparam bit CFG_OK = (MAX_OUT >= 2) && (MAX_OUT <= 16) &&
                            ((MAX_OUT & (MAX_OUT - 1)) == 0) &&
                            (TIMEOUT_CYC >= 2);

    req_t [1:0] req;
    assign req[0] = {req0_valid, req0_data};
    assign req[1] = {req1_valid, req1_data};

    arb_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    req_id_t          last_grant, grant, head_id;
    logic             can_issue, issue, pop, expire, tag_empty;
    logic [1:0]       rdy;

    // Grant / issue. Ready is derived from the registered cnt, so a pop in
    // the same cycle never opens a slot at cnt == MAX_OUT.
    always_comb begin
        grant = 1'b0;
        if (req[0].vld && req[1].vld)
            grant = ~last_grant;
        else if (req[1].vld)
            grant = 1'b1;
        can_issue = CFG_OK && !HRESET && (cnt < CNT_MAX) && (state != FLUSH);
        issue     = can_issue && (req[0].vld || req[1].vld);
        rdy       = '0;
        if (issue)
            rdy[grant] = 1'b1;
    end

    assign req0_ready   = rdy[0];
    assign req1_ready   = rdy[1];
    assign cor_valid_in = issue;
    assign cor_in       = issue ? req[grant].data : '0;
    assign busy         = (cnt != '0);

    // A return with nothing in flight is spurious and simply dropped.
    assign pop = cor_valid_out && !tag_empty;

    always_comb begin
        cnt_nxt = cnt + CNT_W'(issue) - CNT_W'(pop);
        if (expire)
            cnt_nxt = '0;
    end

    cordic_tag_fifo #(
        .DEPTH (MAX_OUT)
    ) u_tag_fifo (
        .HCLK    (HCLK),
        .HRESET  (HRESET),
        .flush   (expire),
        .push    (issue),
        .push_id (grant),
        .pop     (pop),
        .head_id (head_id),
        .empty   (tag_empty)
    );

`ifdef CORDIC_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC);
    // Expire on the quiet cycle that would take the counter to
    // TIMEOUT_CYC-1, so FLUSH lands TIMEOUT_CYC cycles after the last
    // activity.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 2);

    logic [WD_W-1:0] wdog;

    assign expire      = (state == RUN) && !issue && !pop && (wdog == WD_LAST);
    assign timeout_err = (state == FLUSH);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET)
            wdog <= '0;
        else if (state != RUN || issue || pop || expire)
            wdog <= '0;
        else
            wdog <= wdog + 1'b1;
    end
`else
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // State register
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (issue) state_nxt = RUN;
            RUN: begin
                if (expire)
                    state_nxt = FLUSH;
                else if (cnt_nxt == '0)
                    state_nxt = IDLE;
            end
            FLUSH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            cnt        <= '0;
            last_grant <= 1'b1;   // req0 wins the first contested cycle
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_data   <= '0;
        end else begin
            cnt        <= cnt_nxt;
            rsp0_valid <= pop && (head_id == 1'b0);
            rsp1_valid <= pop && (head_id == 1'b1);
            if (issue)
                last_grant <= grant;
            if (pop)
                rsp_data <= cor_out;
        end
    end

endmodule

// File: doc/cordic_arbiter.md
CORDIC_ARBITER -- requirements
Module: cordic_arbiter

Interface
REQ-001 Parameter MAX_OUT, default 4: max CORDIC jobs in flight; also tag-queue depth; power of two, 2..16.
REQ-002 Parameter TIMEOUT_CYC, default 256: watchdog limit in cycles; used only when CORDIC_ARB_TIMEOUT_EN is defined.
REQ-003 HCLK  input  1  single clock; all state on rising edge.
REQ-004 HRESET  input  1  asynchronous, active-high reset.
REQ-005 req0_valid / req1_valid  input  1 each  requester 0/1 offers an operand word.
REQ-006 req0_data / req1_data  input  32 each  operand word from requester 0/1.
REQ-007 req0_ready / req1_ready  output  1 each  operand accepted this cycle when ANDed with valid.
REQ-008 cor_in  output  32  operand to CORDIC core; 0 when not issuing.
REQ-009 cor_valid_in  output  1  one-cycle issue strobe to core.
REQ-010 cor_valid_out  input  1  core result strobe.
REQ-011 cor_out  input  32  core result word; sampled when cor_valid_out=1.
REQ-012 rsp0_valid / rsp1_valid  output  1 each  one-cycle result pulse to requester 0/1.
REQ-013 rsp_data  output  32  registered result word, shared by both requesters.
REQ-014 busy  output  1  high while any job is outstanding.
REQ-015 timeout_err  output  1  one-cycle watchdog pulse; tied 0 without the macro.

Function
REQ-016 Keep outstanding count cnt, range 0..MAX_OUT; issue allowed only while cnt<MAX_OUT and state is not FLUSH.
REQ-017 Arbitration is round-robin on last_grant.
- Both valid: grant the requester not in last_grant.
- One valid: grant it.
- last_grant updates only on issue.
REQ-018 Ready is combinational and goes only to the granted requester; the other ready is 0 that cycle.
REQ-019 Issue = valid&ready, in the same cycle:
- cor_valid_in=1.
- cor_in = granted data.
- Push requester ID into the tag queue.
- cnt+1.
REQ-020 cor_valid_out with a non-empty tag queue:
- Pop the head ID; cnt-1.
- Next cycle: rsp_data=cor_out and rspN_valid=1 for the popped ID, for exactly one cycle.
- Latency is 1 cycle from cor_valid_out to the response.
REQ-021 Results are routed strictly in issue order; the core is taken to return results in order.
REQ-022 Issue and return in the same cycle: push and pop both happen and cnt is unchanged.
- When cnt=MAX_OUT, no issue occurs even if a pop happens that cycle (ready is computed from the registered cnt).
REQ-023 cor_valid_out with an empty tag queue is spurious: no pop, no response, cnt unchanged.
REQ-024 rsp_data holds its last value between pulses.
REQ-025 busy = (cnt!=0).
REQ-026 State machine:
- IDLE (cnt=0) -> RUN on issue.
- RUN -> IDLE when cnt reaches 0.
- RUN -> FLUSH on watchdog expiry (macro only).
- FLUSH -> IDLE after exactly 1 cycle.

Reset
REQ-027 HRESET asserted at any time, including mid-job:
- Outputs to 0: readies, cor_valid_in, cor_in, rspN_valid, rsp_data, busy, timeout_err.
- state=IDLE, cnt=0, tag queue empty, last_grant=1 (req0 wins first), watchdog=0.
REQ-028 Results arriving after reset release for jobs issued before reset are spurious, handled per REQ-023.

Configuration
REQ-029 Macro CORDIC_ARB_TIMEOUT_EN defined: watchdog enabled.
- Watchdog counter clears on any issue or accepted return, and in IDLE.
- Increments each RUN cycle otherwise.
- On reaching TIMEOUT_CYC-1: enter FLUSH.
- In FLUSH: tag queue emptied, cnt=0, readies 0, timeout_err=1 for that single cycle.
REQ-030 Macro undefined: no watchdog or FLUSH logic; RUN persists until cnt=0; timeout_err constant 0.

Structure
REQ-031 Package cordic_pkg holds:
- Requester-ID type (1 bit).
- State enumeration IDLE/RUN/FLUSH.
- Default MAX_OUT and TIMEOUT_CYC constants.
REQ-032 Tag queue is a sub-module cordic_tag_fifo:
- Synchronous FIFO, depth MAX_OUT, 1-bit entries.
- Simultaneous push/pop allowed, flush input, asynchronous HRESET.

Verification
REQ-033 After reset, req0 and req1 both valid every cycle with core returning after 3 cycles: issue order 0,1,0,1; responses rsp0, rsp1, rsp0, rsp1 in that order, each 1 cycle after its cor_valid_out.
REQ-034 MAX_OUT=4, req0 valid continuously, core stalled: exactly 4 issues; req0_ready stays 0 with cnt=4. Then one cor_valid_out: cnt=3 and the next issue occurs the following cycle.
REQ-035 Issue and return in the same cycle at cnt=2: cnt stays 2; tag order is preserved.
REQ-036 cor_valid_out with cor_out=0x1234_5678 while idle: no rsp pulse, busy stays 0.
REQ-037 Macro defined, TIMEOUT_CYC=16, one job issued, core silent: timeout_err pulses 16 cycles later; busy drops; a later result is ignored.
REQ-038 HRESET pulsed with 3 jobs in flight: busy=0 the cycle after assertion; first post-reset grant goes to req0.
